// File: rtl/inpass_cfg_pkg.sv
// inpass_cfg_pkg: shared constants and FSM state type for the input-pass config controller
package inpass_cfg_pkg;
  localparam int BITS_PER_BEL = 4;
  localparam logic MODE_COMB = 1'b0;
  localparam logic MODE_REG = 1'b1;
  typedef enum logic [1:0] {IDLE, DRAIN, APPLY, ACK} state_t;
endpackage

// File: rtl/inpass_cfg_drain_cnt.sv
// inpass_cfg_drain_cnt: loadable down-counter with zero flag for the commit drain window
module inpass_cfg_drain_cnt #(
  parameter int CntW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            dec,
  input  logic [CntW-1:0] load_val,
  output logic            zero
);
  logic [CntW-1:0] r_cnt;
  assign zero = r_cnt == '0;
  always_ff @(posedge clk)
    if (rst) r_cnt <= '0;
    else if (load) r_cnt <= load_val;
    else if (dec && !zero) r_cnt <= r_cnt - CntW'(1);
endmodule

// File: rtl/inpass_cfg_ctrl.sv
// inpass_cfg_ctrl: shadowed per-BEL nibble writes committed atomically to ConfigBits after a drain window
module inpass_cfg_ctrl
  import inpass_cfg_pkg::*;
#(
  parameter int NumBels = 8,
  parameter int IdxW = 3,
  parameter int DrainCycles = 2,
  parameter int CntW = 4
) (
  input  logic                            UserCLK,
  input  logic                            Reset,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [IdxW-1:0]                 cfg_index,
  input  logic [BITS_PER_BEL-1:0]         cfg_data,
  output logic                            cfg_err,
  input  logic                            commit_req,
  output logic                            commit_ack,
  output logic                            busy,
  output logic                            dirty,
  input  logic [IdxW-1:0]                 rd_index,
  output logic [BITS_PER_BEL-1:0]         rd_data,
  output logic [NumBels*BITS_PER_BEL-1:0] ConfigBits
);
  localparam int W = NumBels * BITS_PER_BEL;
  localparam logic [CntW-1:0] LOAD = CntW'(DrainCycles > 0 ? DrainCycles - 1 : 0);
  state_t r_state, w_next;
  logic [W-1:0] r_shadow, r_cfg;
  logic [BITS_PER_BEL-1:0] r_rd, w_rd;
  logic r_dirty, r_err, w_wr, w_hit, w_zero;
  assign cfg_ready = r_state == IDLE;
  assign busy = !cfg_ready;
  assign commit_ack = r_state == ACK;
  assign cfg_err = r_err;
  assign dirty = r_dirty;
  assign rd_data = r_rd;
  assign ConfigBits = r_cfg;
  assign w_wr = cfg_valid & cfg_ready;
  inpass_cfg_drain_cnt #(.CntW(CntW)) u_cnt (
    .clk(UserCLK),
    .rst(Reset),
    .load(cfg_ready & commit_req),
    .dec(r_state == DRAIN),
    .load_val(LOAD),
    .zero(w_zero)
  );
  always_comb begin
    w_next = r_state;
    w_hit = 1'b0;
    w_rd = '0;
    case (r_state)
      IDLE:    w_next = commit_req ? (DrainCycles == 0 ? APPLY : DRAIN) : IDLE;
      DRAIN:   w_next = w_zero ? APPLY : DRAIN;
      APPLY:   w_next = ACK;
      default: w_next = IDLE;
    endcase
    for (int k = 0; k < NumBels; k++) begin
      w_hit = w_hit | (cfg_index == IdxW'(k));
      if (rd_index == IdxW'(k)) w_rd = r_cfg[k*BITS_PER_BEL +: BITS_PER_BEL];
    end
  end
  always_ff @(posedge UserCLK)
    if (Reset) begin
      r_state <= IDLE;
      r_shadow <= {W{MODE_COMB}};
      r_cfg <= {W{MODE_COMB}};
      r_dirty <= 1'b0;
      r_err <= 1'b0;
      r_rd <= '0;
    end else begin
      r_state <= w_next;
      r_err <= w_wr & ~w_hit;
      r_rd <= w_rd;
      for (int k = 0; k < NumBels; k++)
        if (w_wr && cfg_index == IdxW'(k)) r_shadow[k*BITS_PER_BEL +: BITS_PER_BEL] <= cfg_data;
      if (w_wr && w_hit) r_dirty <= 1'b1;
      else if (r_state == APPLY) r_dirty <= 1'b0;
      if (r_state == APPLY) r_cfg <= r_shadow;
    end
endmodule

// File: doc/inpass_cfg_ctrl.md
Name: inpass_cfg_ctrl

Overview:
Configuration controller for a bank of NumBels 4-bit input-pass BELs. Each BEL has one select bit per lane: 0 = combinational, 1 = registered. A host writes per-BEL 4-bit configuration nibbles into a shadow register over a valid/ready handshake. On request, the block commits the shadow register atomically to the live ConfigBits bus, after a programmable drain window so in-flight registered data settles. It sits between the tile configuration interface and the BEL ConfigBits inputs, and provides registered readback of the live configuration.

Parameters:
NumBels, 8, number of 4-bit BELs controlled; ConfigBits width = NumBels*4
IdxW, 3, width of BEL index; must satisfy 2**IdxW >= NumBels
DrainCycles, 2, cycles the block waits between commit acceptance and apply (0 allowed)
CntW, 4, drain counter width; must satisfy 2**CntW > DrainCycles

Ports:
UserCLK  input  1  single clock, rising edge
Reset  input  1  synchronous, active-high reset
cfg_valid  input  1  host nibble write request
cfg_ready  output  1  block can accept a write
cfg_index  input  IdxW  target BEL index
cfg_data  input  4  per-lane select bits for that BEL
cfg_err  output  1  one-cycle pulse: an accepted write had an out-of-range index
commit_req  input  1  request to apply shadow to live; sampled only in IDLE
commit_ack  output  1  one-cycle pulse; live ConfigBits updated this cycle
busy  output  1  high whenever state != IDLE
dirty  output  1  shadow differs from last commit (set by write, cleared by apply)
rd_index  input  IdxW  readback BEL index
rd_data  output  4  live ConfigBits nibble for rd_index, 1-cycle latency
ConfigBits  output  NumBels*4  live config to BELs; bits [4k+3:4k] belong to BEL k

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports UserCLK and Reset).
- Reset values:
  - ConfigBits=0 (all lanes combinational); shadow=0.
  - cfg_ready=1, cfg_err=0, commit_ack=0, busy=0, dirty=0, rd_data=0.
  - State=IDLE; drain count=0.
- cfg_ready=1 only in IDLE.
- Write accept (cfg_valid & cfg_ready):
  - cfg_index < NumBels: shadow[4*idx +: 4] <= cfg_data; dirty <= 1.
  - cfg_index >= NumBels: shadow unchanged, dirty unchanged, cfg_err=1 next cycle for exactly one cycle.
- FSM states: IDLE, DRAIN, APPLY, ACK.
  - IDLE: commit_req=1 -> DRAIN with count=DrainCycles. If DrainCycles==0, go directly to APPLY.
  - DRAIN: decrement count each cycle; occupies exactly DrainCycles cycles, then APPLY.
  - APPLY: ConfigBits <= shadow; dirty <= 0; next ACK.
  - ACK: commit_ack=1 for this cycle only; next IDLE.
- Latency: commit_req high in IDLE at cycle t -> new ConfigBits and commit_ack both visible at cycle t+DrainCycles+2; cfg_ready returns to 1 at t+DrainCycles+3.
- Simultaneous cfg write and commit_req in IDLE: the write is accepted and included in that commit.
- commit_req while busy: ignored, not queued.
- Commit with dirty=0: still runs the full sequence and pulses commit_ack; ConfigBits value is unchanged.
- Shadow is never visible on ConfigBits except via APPLY; ConfigBits changes on no other cycle.
- Readback: rd_data <= ConfigBits[4*rd_index +: 4] each cycle; rd_data=0 for rd_index >= NumBels.
- Reset asserted mid-commit: returns all state to reset values next edge; the pending commit is discarded and no ack is issued.

Decomposition:
- Package inpass_cfg_pkg: BITS_PER_BEL=4 constant, FSM state enum (IDLE/DRAIN/APPLY/ACK), lane-mode constants MODE_COMB=0, MODE_REG=1.
- One sub-module: inpass_cfg_drain_cnt, a loadable down-counter (load, dec, zero flag, width CntW).
- Shadow storage, write decode and readback mux stay in the top module.

Test Plan:
- Reset then idle: after Reset held 2 cycles -> ConfigBits=0x00000000, cfg_ready=1, busy=0, dirty=0, rd_data=0 for index 0..7.
- Write idx3=0xA, idx0=0x5, then commit_req at cycle t (DrainCycles=2) -> ConfigBits=0x0000A005 and commit_ack=1 exactly at t+4, busy high t+1..t+4, dirty=0 after, rd_index=3 gives 0xA next cycle.
- Write with cfg_index=7 and NumBels=6 -> cfg_err pulses one cycle, dirty unchanged, shadow unchanged, and a subsequent commit leaves ConfigBits unchanged.
- Same-cycle write idx1=0xF plus commit_req -> commit includes nibble: ConfigBits[7:4]=0xF at ack; second commit_req asserted during DRAIN -> ignored, single ack.
- DrainCycles=0 build: commit_req at t -> ack and new ConfigBits at t+2; back-to-back commits each take 3 cycles.
- Reset asserted in DRAIN after write idx2=0xC -> no commit_ack, ConfigBits stays 0, shadow=0, dirty=0.
